// File: rtl/gate_pkg.sv
// Shared constants and elaboration helpers for the gate-input conditioning stage.
package gate_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_CNT_W         = 3;

  // True when a CNT_W-bit counter can hold the terminal count STABLE_CYCLES-1.
  function automatic bit cnt_w_fits(input int stable_cycles, input int cnt_w);
    return (64'(1) << cnt_w) > 64'(stable_cycles - 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, stability filter, registered rise/fall pulses.
module debounce_channel
  import gate_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic w_mismatch;
  logic w_accept;

  assign w_mismatch = (r_sync2 != r_level);
  assign w_accept   = en && w_mismatch && (r_cnt == LP_CNT_LAST);

  // Synchroniser keeps shifting regardless of en so no stale sample is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any match or acceptance clears the count, so a glitch earns no partial credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_accept &&  r_sync2;
      r_fall <= w_accept && !r_sync2;
      if (en) begin
        if (!w_mismatch || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_accept) begin
          r_level <= r_sync2;
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/gate_input_debouncer.sv
// Conditions two raw asynchronous levels into clean a/b operands for the downstream and_gate.
module gate_input_debouncer
  import gate_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
    $error("gate_input_debouncer: STABLE_CYCLES must be >= 2");
  end
  if (!cnt_w_fits(STABLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
    $error("gate_input_debouncer: CNT_W too narrow for STABLE_CYCLES-1");
  end

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .raw   (a_raw),
    .level (a),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .raw   (b_raw),
    .level (b),
    .rise  (b_rise),
    .fall  (b_fall)
  );

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Directed and randomized checks of gate_input_debouncer against a sample-history reference model.
module tb_gate_input_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n, en, a_raw, b_raw;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel keeps the raw samples still in flight (two-edge delay)
  // and the length of the current run of enabled edges that disagreed with the output.
  logic mq_a[$];
  logic mq_b[$];
  int   run_a, run_b;
  logic ma, mb, ma_r, ma_f, mb_r, mb_f;

  always #5 clk = ~clk;

  gate_input_debouncer #(.STABLE_CYCLES(N), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a),
    .b      (b),
    .a_rise (a_rise),
    .a_fall (a_fall),
    .b_rise (b_rise),
    .b_fall (b_fall)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_a.delete(); mq_a.push_back(1'b0); mq_a.push_back(1'b0);
    mq_b.delete(); mq_b.push_back(1'b0); mq_b.push_back(1'b0);
    run_a = 0; run_b = 0;
    ma = 1'b0; mb = 1'b0;
    ma_r = 1'b0; ma_f = 1'b0; mb_r = 1'b0; mb_f = 1'b0;
  endtask

  task automatic chan_edge(input logic seen, input logic e, inout logic out, inout int run,
                           output logic r, output logic f);
    r = 1'b0;
    f = 1'b0;
    if (e) begin
      if (seen != out) begin
        run++;
        if (run == N) begin
          r   = seen;
          f   = !seen;
          out = seen;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic sa, sb;
    sa = mq_a.pop_front();
    sb = mq_b.pop_front();
    mq_a.push_back(a_raw);
    mq_b.push_back(b_raw);
    chan_edge(sa, en, ma, run_a, ma_r, ma_f);
    chan_edge(sb, en, mb, run_b, mb_r, mb_f);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"},      a,      ma);
    chk({tag, ".b"},      b,      mb);
    chk({tag, ".a_rise"}, a_rise, ma_r);
    chk({tag, ".a_fall"}, a_fall, ma_f);
    chk({tag, ".b_rise"}, b_rise, mb_r);
    chk({tag, ".b_fall"}, b_fall, mb_f);
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic ra, input logic rb, input logic e, input string tag);
    a_raw = ra;
    b_raw = rb;
    en    = e;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic hold(input logic ra, input logic rb, input int n, input string tag);
    for (int i = 0; i < n; i++) step(ra, rb, 1'b1, tag);
  endtask

  initial begin
    int first_a, first_b, cnt_r, cnt_f, fall_at, rise_at;
    logic ra, rb;

    // 1: reset with raws high, then release and measure latency
    rst_n = 1'b0; en = 1'b1; a_raw = 1'b1; b_raw = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_all("rst_hold");
    hold(1'b1, 1'b1, 3, "rst_hold");
    rst_n = 1'b1;
    first_a = -1; first_b = -1; cnt_r = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b1, "rel");
      if (a === 1'b1 && first_a < 0) first_a = i;
      if (b === 1'b1 && first_b < 0) first_b = i;
      if (a_rise === 1'b1) cnt_r++;
    end
    chk_int("rel_lat_a", first_a, N + 2);
    chk_int("rel_lat_b", first_b, N + 2);
    chk_int("rel_a_rise_cnt", cnt_r, 1);

    // 2: glitch of 2 cycles on a steady-low a
    hold(1'b0, 1'b0, 8, "to_low");
    cnt_r = 0;
    hold(1'b1, 1'b0, 2, "glitch");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, "glitch");
      if (a_rise === 1'b1) cnt_r++;
    end
    chk_int("glitch_rise_cnt", cnt_r, 0);
    chk("glitch_a", a, 1'b0);

    // 3: boundary, 4 cycles accepted, 3 rejected
    cnt_r = 0;
    for (int i = 0; i < 4 + 8; i++) begin
      step(i < 4, 1'b0, 1'b1, "bound4");
      if (a_rise === 1'b1) cnt_r++;
    end
    chk_int("bound4_rise_cnt", cnt_r, 1);
    hold(1'b0, 1'b0, 8, "to_low");
    chk("bound_pre_a", a, 1'b0);
    cnt_r = 0;
    for (int i = 0; i < 3 + 8; i++) begin
      step(i < 3, 1'b0, 1'b1, "bound3");
      if (a_rise === 1'b1) cnt_r++;
    end
    chk_int("bound3_rise_cnt", cnt_r, 0);

    // 4: a falls while b rises on the same edge; and_gate output stays low
    hold(1'b1, 1'b0, 8, "a1b0");
    chk("a1b0_a", a, 1'b1);
    chk("a1b0_b", b, 1'b0);
    fall_at = -1; rise_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b1, "swap");
      chk("swap_and_y", a & b, 1'b0);
      if (a_fall === 1'b1) fall_at = i;
      if (b_rise === 1'b1) rise_at = i;
    end
    chk_int("swap_fall_at", fall_at, N + 2);
    chk_int("swap_rise_at", rise_at, N + 2);

    // 5: enable low mid-count holds the count
    hold(1'b1, 1'b1, 4, "en_cnt");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, "en_off");
    chk("en_off_a", a, 1'b0);
    first_a = -1;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b1, "en_on");
      if (a === 1'b1 && first_a < 0) first_a = i;
    end
    chk_int("en_resume_lat", first_a, 2);

    // 6: reset mid-count, then full latency after release
    hold(1'b0, 1'b0, 8, "to_low");
    hold(1'b1, 1'b1, 3, "pre_rst");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    hold(1'b1, 1'b1, 2, "rst_mid");
    rst_n = 1'b1;
    first_a = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b1, "rel2");
      if (a === 1'b1 && first_a < 0) first_a = i;
    end
    chk_int("rel2_lat_a", first_a, N + 2);

    // Randomized phase
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rand_rst");
        step(ra, rb, 1'b1, "rand_rst");
        rst_n = 1'b1;
      end
      step(ra, rb, $urandom_range(0, 9) != 0, "rand");
      chk("rand_a_excl", a_rise & a_fall, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
